if_id_fetch: RTL and testbench

Instruction-fetch tail plus IF/ID pipeline register for the in-order MIPS core. It sits directly downstream of the PC register and consumes its `pc`/`ce` outputs. It drives the synchronous instruction SRAM port, tracks which PC each returning word belongs to, and preserves that word across pipeline stalls. It presents `pc`, `inst` and an address-error flag to the decode stage, with stall-bubble and flush support.

---
 rtl/if_id_fetch.sv | 104 ++++++++++
 tb/tb_if_id_fetch.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_fetch.sv
// if_id_fetch: instruction-fetch tail and IF/ID pipeline register.
// Drives the synchronous instruction SRAM from the PC register outputs and
// tracks which PC each returning word belongs to. A one-word hold buffer
// keeps that word intact across stalls, because the PC keeps re-issuing the
// next address to the SRAM. Results go to decode with bubble and flush support.
module if_id_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        ce,
  input  logic [5:0]  stall,
  input  logic        flush,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_wen,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_valid,
  output logic        id_adel
);

  // F stage: describes the request whose data is on inst_sram_rdata this cycle
  logic        f_valid;
  logic [31:0] f_pc;
  logic        f_adel;

  // Hold buffer: the word for f_pc, captured on the first stalled edge
  logic        hold_valid;
  logic [31:0] hold_inst;

  logic [31:0] f_inst;
  logic        pc_aligned;
  logic        stall_f;
  logic        stall_d;

  // Only stall[1] (F) and stall[2] (ID) matter here; stall[0] mirrors stall[1]
  logic        unused_stall;
  assign unused_stall = ^{stall[5:3], stall[0]};

  assign stall_f    = stall[1];
  assign stall_d    = stall[2];
  assign pc_aligned = (pc[1:0] == 2'b00);

  // A misaligned PC never reaches the SRAM; it is reported as AdEL instead
  assign inst_sram_en    = ce & ~rst & pc_aligned;
  assign inst_sram_wen   = 4'h0;
  assign inst_sram_addr  = pc;
  assign inst_sram_wdata = 32'h0;

  // Faulting fetches carry a zero word; otherwise prefer the protected copy
  assign f_inst = f_adel     ? 32'h0 :
                  hold_valid ? hold_inst : inst_sram_rdata;

  // F-stage tracking registers: follow the PC unless stalled, die on flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_valid <= 1'b0;
      f_pc    <= 32'h0;
      f_adel  <= 1'b0;
    end else if (flush) begin
      f_valid <= 1'b0;
    end else if (!stall_f) begin
      f_valid <= ce;
      f_pc    <= pc;
      f_adel  <= ~pc_aligned;
    end
  end

  // Hold buffer: grab the returning word once per stall, drop it on release/flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_inst  <= 32'h0;
    end else if (flush || !stall_f) begin
      hold_valid <= 1'b0;
    end else if (f_valid && !hold_valid) begin
      hold_valid <= 1'b1;
      hold_inst  <= inst_sram_rdata;
    end
  end

  // IF/ID register: flush and F-stalled-but-ID-running both insert a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_pc    <= 32'h0;
      id_inst  <= 32'h0;
      id_valid <= 1'b0;
      id_adel  <= 1'b0;
    end else if (flush || (stall_f && !stall_d)) begin
      id_pc    <= 32'h0;
      id_inst  <= 32'h0;
      id_valid <= 1'b0;
      id_adel  <= 1'b0;
    end else if (!stall_f) begin
      id_pc    <= f_pc;
      id_inst  <= f_inst;
      id_valid <= f_valid;
      id_adel  <= f_valid & f_adel;
    end
  end

endmodule

// File: tb/tb_if_id_fetch.sv
// tb_if_id_fetch: bench for if_id_fetch with a behavioural PC register,
// a synchronous instruction SRAM and an ID-stage scoreboard.
module tb_if_id_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc = 32'hbfc00000;
  logic        ce = 1'b0;
  logic [5:0]  stall = 6'b0;
  logic        flush = 1'b0;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
  logic        id_adel;

  int checks = 0;
  int errors = 0;
  logic [31:0] redir_pc = 32'hbfc00380;

  typedef struct packed {
    logic        known;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
    logic        adel;
  } exp_t;

  exp_t exp_q[$];
  exp_t m_id;
  logic        m_fv;
  logic [31:0] m_fpc;
  logic        m_fadel;

  if_id_fetch dut (
    .clk(clk), .rst(rst), .pc(pc), .ce(ce), .stall(stall), .flush(flush),
    .inst_sram_en(inst_sram_en), .inst_sram_wen(inst_sram_wen),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata),
    .id_pc(id_pc), .id_inst(id_inst), .id_valid(id_valid), .id_adel(id_adel)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'hbfc00000) return 32'h24010001;
    if (a == 32'hbfc00004) return 32'h24020002;
    return {8'h20, a[23:0]};
  endfunction

  // Synchronous SRAM: data for the sampled address appears the next cycle
  always @(posedge clk or posedge rst) begin
    if (rst) inst_sram_rdata <= 32'h0;
    else     inst_sram_rdata <= inst_sram_en ? mem(inst_sram_addr) : 32'h0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    m_fv    = 1'b0;
    m_fpc   = 32'h0;
    m_fadel = 1'b0;
    m_id    = '{known: 1'b1, pc: 32'h0, inst: 32'h0, valid: 1'b0, adel: 1'b0};
    exp_q.delete();
  endtask

  // One clock: predict the ID stage, advance the PC register, score the DUT
  task automatic tick();
    exp_t e;
    if (flush) begin
      m_fv = 1'b0;
      m_id = '{known: 1'b1, pc: 32'h0, inst: 32'h0, valid: 1'b0, adel: 1'b0};
    end else if (stall[1] && !stall[2]) begin
      m_id = '{known: 1'b1, pc: 32'h0, inst: 32'h0, valid: 1'b0, adel: 1'b0};
    end else if (!stall[1]) begin
      m_id.known = m_fv;
      m_id.pc    = m_fpc;
      m_id.valid = m_fv;
      m_id.adel  = m_fv & m_fadel;
      m_id.inst  = (m_fv && !m_fadel) ? mem(m_fpc) : 32'h0;
      m_fv    = ce;
      m_fpc   = pc;
      m_fadel = (pc[1:0] != 2'b00);
    end
    exp_q.push_back(m_id);
    @(posedge clk);
    #1;
    if (flush)          pc = redir_pc;
    else if (!ce)       ce = 1'b1;
    else if (!stall[0]) pc = pc + 32'd4;
    e = exp_q.pop_front();
    checks++;
    if (e.known) begin
      if ({id_pc, id_inst, id_valid, id_adel} !== {e.pc, e.inst, e.valid, e.adel}) begin
        errors++;
        $display("FAIL scoreboard t=%0t got pc=%h inst=%h v=%b adel=%b want pc=%h inst=%h v=%b adel=%b",
                 $time, id_pc, id_inst, id_valid, id_adel, e.pc, e.inst, e.valid, e.adel);
      end
    end else if ({id_valid, id_adel} !== {e.valid, e.adel}) begin
      errors++;
      $display("FAIL scoreboard_ctl t=%0t got v=%b adel=%b want v=%b adel=%b",
               $time, id_valid, id_adel, e.valid, e.adel);
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    ce = 1'b1;
    pc = 32'hbfc00000;
    #1;
    checks++;
    if (inst_sram_en !== 1'b0) begin
      errors++; $display("FAIL reset_en got %b want 0", inst_sram_en);
    end
    checks++;
    if ({id_pc, id_inst, id_valid, id_adel} !== 66'h0) begin
      errors++; $display("FAIL reset_id got pc=%h inst=%h v=%b adel=%b want all 0", id_pc, id_inst, id_valid, id_adel);
    end
    checks++;
    if ({inst_sram_wen, inst_sram_wdata, inst_sram_addr} !== {4'h0, 32'h0, 32'hbfc00000}) begin
      errors++; $display("FAIL reset_sram_port got wen=%h wdata=%h addr=%h want 0 0 bfc00000",
                         inst_sram_wen, inst_sram_wdata, inst_sram_addr);
    end
    ce = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_straight();
    repeat (3) tick();
    checks++;
    if ({id_pc, id_inst, id_valid} !== {32'hbfc00000, 32'h24010001, 1'b1}) begin
      errors++; $display("FAIL first_fetch got pc=%h inst=%h v=%b want bfc00000 24010001 1", id_pc, id_inst, id_valid);
    end
  endtask

  task automatic test_stall();
    int seen = 0;
    stall = 6'b000011;
    repeat (3) begin
      tick();
      checks++;
      if (id_valid !== 1'b0) begin
        errors++; $display("FAIL stall_bubble got v=%b want 0", id_valid);
      end
    end
    stall = 6'b0;
    tick();
    if (id_inst === 32'h24020002) seen++;
    checks++;
    if ({id_pc, id_inst, id_valid} !== {32'hbfc00004, 32'h24020002, 1'b1}) begin
      errors++; $display("FAIL stall_release got pc=%h inst=%h v=%b want bfc00004 24020002 1", id_pc, id_inst, id_valid);
    end
    tick();
    if (id_inst === 32'h24020002) seen++;
    checks++;
    if ({id_pc, id_inst} !== {32'hbfc00008, mem(32'hbfc00008)}) begin
      errors++; $display("FAIL after_release got pc=%h inst=%h want bfc00008 %h", id_pc, id_inst, mem(32'hbfc00008));
    end
    checks++;
    if (seen != 1) begin
      errors++; $display("FAIL release_once got %0d copies want 1", seen);
    end
  endtask

  task automatic test_bubble();
    stall = 6'b000111;
    tick();
    checks++;
    if ({id_pc, id_inst, id_valid} !== {32'hbfc00008, mem(32'hbfc00008), 1'b1}) begin
      errors++; $display("FAIL id_hold got pc=%h inst=%h v=%b want bfc00008 %h 1", id_pc, id_inst, id_valid, mem(32'hbfc00008));
    end
    stall = 6'b000011;
    tick();
    checks++;
    if ({id_inst, id_valid} !== {32'h0, 1'b0}) begin
      errors++; $display("FAIL bubble got inst=%h v=%b want 0 0", id_inst, id_valid);
    end
    stall = 6'b0;
    tick();
    checks++;
    if ({id_pc, id_valid} !== {32'hbfc0000c, 1'b1}) begin
      errors++; $display("FAIL after_bubble got pc=%h v=%b want bfc0000c 1", id_pc, id_valid);
    end
  endtask

  task automatic test_flush();
    stall = 6'b000011;
    tick();
    checks++;
    if (dut.hold_valid !== 1'b1) begin
      errors++; $display("FAIL hold_capture got %b want 1", dut.hold_valid);
    end
    flush = 1'b1;
    redir_pc = 32'hbfc00380;
    tick();
    flush = 1'b0;
    stall = 6'b0;
    checks++;
    if ({id_valid, dut.hold_valid} !== 2'b00) begin
      errors++; $display("FAIL flush_clear got v=%b hold=%b want 0 0", id_valid, dut.hold_valid);
    end
    repeat (2) tick();
    checks++;
    if ({id_pc, id_inst, id_valid} !== {32'hbfc00380, mem(32'hbfc00380), 1'b1}) begin
      errors++; $display("FAIL redirect got pc=%h inst=%h v=%b want bfc00380 %h 1", id_pc, id_inst, id_valid, mem(32'hbfc00380));
    end
  endtask

  task automatic test_misaligned();
    pc = 32'hbfc00002;
    #1;
    checks++;
    if (inst_sram_en !== 1'b0) begin
      errors++; $display("FAIL misaligned_en got %b want 0", inst_sram_en);
    end
    tick();
    pc = 32'hbfc00010;
    tick();
    checks++;
    if ({id_pc, id_inst, id_valid, id_adel} !== {32'hbfc00002, 32'h0, 1'b1, 1'b1}) begin
      errors++; $display("FAIL adel got pc=%h inst=%h v=%b adel=%b want bfc00002 0 1 1", id_pc, id_inst, id_valid, id_adel);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] prev;
    tick();
    prev = id_pc;
    repeat (5) begin
      tick();
      checks++;
      if ({id_pc, id_valid} !== {prev + 32'd4, 1'b1}) begin
        errors++; $display("FAIL back_to_back got pc=%h v=%b want %h 1", id_pc, id_valid, prev + 32'd4);
      end
      prev = id_pc;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 5))
        0:       stall = 6'b000011;
        1:       stall = 6'b000111;
        default: stall = 6'b0;
      endcase
      flush = ($urandom_range(0, 15) == 0);
      redir_pc = 32'hbfc00380 + {$urandom_range(0, 15), 4'h0};
      tick();
    end
    flush = 1'b0;
    stall = 6'b0;
    repeat (3) tick();
  endtask

  task automatic test_async_reset();
    stall = 6'b000011;
    repeat (2) tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({id_pc, id_inst, id_valid, id_adel, dut.hold_valid, inst_sram_en} !== 68'h0) begin
      errors++; $display("FAIL async_reset got pc=%h inst=%h v=%b adel=%b hold=%b en=%b want all 0",
                         id_pc, id_inst, id_valid, id_adel, dut.hold_valid, inst_sram_en);
    end
    pc = 32'hbfc00000;
    ce = 1'b0;
    stall = 6'b0;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) tick();
    checks++;
    if ({id_pc, id_inst, id_valid} !== {32'hbfc00000, 32'h24010001, 1'b1}) begin
      errors++; $display("FAIL restart got pc=%h inst=%h v=%b want bfc00000 24010001 1", id_pc, id_inst, id_valid);
    end
    tick();
    checks++;
    if ({id_pc, id_inst} !== {32'hbfc00004, 32'h24020002}) begin
      errors++; $display("FAIL restart_second got pc=%h inst=%h want bfc00004 24020002", id_pc, id_inst);
    end
  endtask

  initial begin
    test_reset();
    test_straight();
    test_stall();
    test_bubble();
    test_flush();
    test_misaligned();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
